fir_core_fsm: RTL and testbench
===============================

# fir_core_fsm

Five-tap FIR filter core with its sequencing state machine, 8-bit samples and 8-bit coefficients. Each accepted input sample shifts a five-entry delay line and triggers a five-cycle multiply-accumulate loop. The result is then scaled and saturated into an 8-bit output register. The block sits under the Tiny Tapeout top-level `tt_um_Richard28277`, which maps its ports onto the pad ring.

## Interface
- No parameters; all widths fixed.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — reset, synchronous and active-high.
- `Shift_Accum_Loop_C_0_tr0` in 1 — sample strobe; sampled only in state WAIT.
- `x_rsc_dat` in 8 — input sample, unsigned; captured when the strobe is accepted.
- `input_0` … `input_4` in 8 each — tap coefficients c0..c4, unsigned Q0.8.
  - Read combinationally during the ACC loop and must be held stable for it.
- `sel` in 3 — output view select.
- `fsm_output` out 8 — one-hot state vector: WAIT=0x01, ACC=0x04, WRITE=0x08.
  - Bit 1 and bits 7:4 are always 0.
- `y_rsc_dat` out 8 — filtered output or debug view, selected by `sel`.
- `y_triosy_lz` out 1 — registered one-cycle pulse: new filter result available.
- `x_triosy_lz` out 1 — registered one-cycle pulse: input sample consumed.

## Operation
- Registered state:
  - delay line d0..d4, 8 b each (d0 newest)
  - accumulator `acc`, 19 b
  - tap counter k, 3 b
  - output register `y_reg`, 8 b
  - state register
  - two pulse flops
- WAIT: if the strobe is 1:
  - shift the delay line: d0<=x_rsc_dat, di<=d(i-1)
  - acc<=0, k<=0
  - next state ACC
  - otherwise hold all state.
- ACC: acc<=acc+dk*ck each cycle (16-bit product, zero-extended), k<=k+1.
  - After the k=4 update, go to WRITE.
  - Exactly 5 cycles; the strobe is ignored.
- WRITE: y_reg<=sat(acc), then unconditionally return to WAIT.
  - sat(acc) = acc[15:8] if acc[18:16]==0, else 0xFF.
- `y_rsc_dat` mux (combinational):
  - sel=0: y_reg
  - sel=1..5: d(sel-1)
  - sel=6,7: 0x00
- `x_triosy_lz` is high exactly in the first ACC cycle after each capture.
- `y_triosy_lz` is high exactly in the WAIT cycle following each WRITE.
- Reset (any state, including mid-loop):
  - state WAIT, fsm_output=0x01
  - d0..d4=0, acc=0, k=0, y_reg=0
  - both pulses 0
  - with sel=0, y_rsc_dat=0x00
  - an aborted computation produces no output.

## Timing
- Capture edge E0 (WAIT with strobe=1) → ACC during cycles after E0..E4 → WRITE after E5.
  - y_reg updates at E6, together with the y_triosy_lz pulse.
- Latency: 6 clock edges from capture to a valid y.
- Throughput: at most one sample per 7 cycles (WAIT lasts at least one cycle).
- Strobe held high continuously: a new capture on every WAIT cycle, i.e. every 7 cycles.
- Strobe asserted in ACC/WRITE: ignored, not queued.
- Coefficient changes during ACC take effect on the tap being processed in that cycle. There is no internal coefficient capture.
- `rst` asserted together with the strobe: reset wins.

## Test plan
- Reset with sel=0 → fsm_output=0x01, y_rsc_dat=0x00, y_triosy_lz=0, x_triosy_lz=0. Check each of sel=1..5 → 0x00.
- Coefficients 0x00,0x01,0x02,0x03,0x04, strobe with x=0xAA:
  - fsm_output sequence 0x01, then 0x04 ×5, 0x08, 0x01
  - x_triosy_lz pulses in the first ACC cycle
  - y=0x00, since only d0 is nonzero and c0=0
  - sel=1 shows 0xAA; sel=5 shows 0x00.
- c0=0x80, others 0, x=0xAA → acc=0x5500, y=0x55. y_triosy_lz pulses exactly 6 edges after capture.
- c1=0xFF, others 0, samples 0x10 then 0x20:
  - first y=0x00
  - second y=0x0F (0x10×0xFF=0x0FF0)
  - sel=2 shows 0x10.
- All coefficients 0xFF, five samples of 0xFF → acc=0x4F605, saturates to y=0xFF.
- Assert rst for one cycle during the third ACC cycle:
  - fsm_output=0x01 next cycle, delay line cleared
  - no y_triosy_lz pulse
  - a strobe during ACC/WRITE is ignored (no extra capture).

Source files
------------

// File: rtl/fir_core_fsm.sv
// Five-tap FIR core: sample capture into a delay line, five-cycle serial MAC,
// then scale/saturate into an 8-bit output register. Sequenced by a 3-state FSM.
module fir_core_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       Shift_Accum_Loop_C_0_tr0,
  input  logic [7:0] x_rsc_dat,
  input  logic [7:0] input_0,
  input  logic [7:0] input_1,
  input  logic [7:0] input_2,
  input  logic [7:0] input_3,
  input  logic [7:0] input_4,
  input  logic [2:0] sel,
  output logic [7:0] fsm_output,
  output logic [7:0] y_rsc_dat,
  output logic       y_triosy_lz,
  output logic       x_triosy_lz
);

  typedef enum logic [1:0] {StWait, StAcc, StWrite} state_e;

  state_e          state_q, state_d;
  logic [4:0][7:0] d_q, d_d;
  logic [18:0]     acc_q, acc_d;
  logic [2:0]      k_q, k_d;
  logic [7:0]      y_reg_q, y_reg_d;
  logic            y_pulse_q, y_pulse_d;
  logic            x_pulse_q, x_pulse_d;

  logic            capture;
  logic [7:0]      tap_d, tap_c;
  logic [15:0]     prod;
  logic [7:0]      sat_val;

  // Select the delay-line entry and coefficient for the tap being processed.
  always_comb begin
    tap_d = 8'h00;
    tap_c = 8'h00;
    case (k_q)
      3'd0:    begin tap_d = d_q[0]; tap_c = input_0; end
      3'd1:    begin tap_d = d_q[1]; tap_c = input_1; end
      3'd2:    begin tap_d = d_q[2]; tap_c = input_2; end
      3'd3:    begin tap_d = d_q[3]; tap_c = input_3; end
      3'd4:    begin tap_d = d_q[4]; tap_c = input_4; end
      default: begin tap_d = 8'h00;  tap_c = 8'h00;   end
    endcase
  end

  assign prod    = 16'(tap_d) * 16'(tap_c);
  // Q0.8 coefficients: drop the fractional byte, clamp anything past 8 integer bits.
  assign sat_val = (acc_q[18:16] == 3'd0) ? acc_q[15:8] : 8'hFF;

  // Next-state and one-hot state decode.
  always_comb begin
    state_d    = state_q;
    fsm_output = 8'h00;
    capture    = 1'b0;
    unique case (state_q)
      StWait: begin
        fsm_output = 8'h01;
        if (Shift_Accum_Loop_C_0_tr0) begin
          capture = 1'b1;
          state_d = StAcc;
        end
      end
      StAcc: begin
        fsm_output = 8'h04;
        if (k_q == 3'd4) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        fsm_output = 8'h08;
        state_d    = StWait;
      end
      default: begin
        state_d = StWait;
      end
    endcase
  end

  // Datapath next-state: delay-line shift, MAC step, output write, pulse generation.
  always_comb begin
    d_d       = d_q;
    acc_d     = acc_q;
    k_d       = k_q;
    y_reg_d   = y_reg_q;
    x_pulse_d = capture;
    y_pulse_d = (state_q == StWrite);
    if (capture) begin
      d_d   = {d_q[3:0], x_rsc_dat};
      acc_d = 19'd0;
      k_d   = 3'd0;
    end else if (state_q == StAcc) begin
      acc_d = acc_q + {3'b000, prod};
      k_d   = k_q + 3'd1;
    end else if (state_q == StWrite) begin
      y_reg_d = sat_val;
    end
  end

  // State register; synchronous reset abandons any computation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q       <= '0;
      acc_q     <= 19'd0;
      k_q       <= 3'd0;
      y_reg_q   <= 8'h00;
      y_pulse_q <= 1'b0;
      x_pulse_q <= 1'b0;
    end else begin
      d_q       <= d_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      y_reg_q   <= y_reg_d;
      y_pulse_q <= y_pulse_d;
      x_pulse_q <= x_pulse_d;
    end
  end

  // Output view: filter result or a delay-line debug tap.
  always_comb begin
    y_rsc_dat = 8'h00;
    case (sel)
      3'd0:    y_rsc_dat = y_reg_q;
      3'd1:    y_rsc_dat = d_q[0];
      3'd2:    y_rsc_dat = d_q[1];
      3'd3:    y_rsc_dat = d_q[2];
      3'd4:    y_rsc_dat = d_q[3];
      3'd5:    y_rsc_dat = d_q[4];
      default: y_rsc_dat = 8'h00;
    endcase
  end

  assign y_triosy_lz = y_pulse_q;
  assign x_triosy_lz = x_pulse_q;

endmodule

// File: tb/tb_fir_core_fsm.sv
// Bench for fir_core_fsm: scenario tasks plus a scoreboard of expected y values
// checked whenever the core announces a new result.
module tb_fir_core_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe;
  logic [7:0] x;
  logic [7:0] c [5];
  logic [2:0] sel;
  logic [7:0] fsm_output;
  logic [7:0] y_rsc_dat;
  logic       y_triosy_lz;
  logic       x_triosy_lz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] md [5];
  logic [7:0] exp_q [$];

  fir_core_fsm dut (
    .clk                      (clk),
    .rst                      (rst),
    .Shift_Accum_Loop_C_0_tr0 (strobe),
    .x_rsc_dat                (x),
    .input_0                  (c[0]),
    .input_1                  (c[1]),
    .input_2                  (c[2]),
    .input_3                  (c[3]),
    .input_4                  (c[4]),
    .sel                      (sel),
    .fsm_output               (fsm_output),
    .y_rsc_dat                (y_rsc_dat),
    .y_triosy_lz              (y_triosy_lz),
    .x_triosy_lz              (x_triosy_lz)
  );

  always #5 clk = ~clk;

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst === 1'b0 && y_triosy_lz === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: y pulse with y=%h, required no pulse", y_rsc_dat);
      end else begin
        e = exp_q.pop_front();
        if (y_rsc_dat !== e) begin
          n_fail++;
          $display("FAIL sb_y: got %h, required %h", y_rsc_dat, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coef(input logic [7:0] a, b, d, e, f);
    c[0] = a; c[1] = b; c[2] = d; c[3] = e; c[4] = f;
  endtask

  task automatic model_capture(input logic [7:0] xv);
    logic [18:0] acc;
    for (int i = 4; i > 0; i--) md[i] = md[i-1];
    md[0] = xv;
    acc = 19'd0;
    for (int i = 0; i < 5; i++) acc = acc + 19'(md[i]) * 19'(c[i]);
    exp_q.push_back((acc[18:16] != 3'd0) ? 8'hFF : acc[15:8]);
  endtask

  task automatic capture(input logic [7:0] xv);
    x      = xv;
    strobe = 1'b1;
    model_capture(xv);
    tick();
    strobe = 1'b0;
  endtask

  task automatic drain();
    int budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) md[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic test_reset();
    strobe = 1'b0; x = 8'h00; sel = 3'd0;
    set_coef(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (fsm_output !== 8'h01) begin
      n_fail++; $display("FAIL reset_fsm: got %h, required 01", fsm_output);
    end
    n_checks++;
    if (y_rsc_dat !== 8'h00) begin
      n_fail++; $display("FAIL reset_y: got %h, required 00", y_rsc_dat);
    end
    n_checks++;
    if (y_triosy_lz !== 1'b0 || x_triosy_lz !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b%b, required 00", y_triosy_lz, x_triosy_lz);
    end
    for (int s = 1; s <= 5; s++) begin
      sel = 3'(s);
      #1;
      n_checks++;
      if (y_rsc_dat !== 8'h00) begin
        n_fail++; $display("FAIL reset_sel%0d: got %h, required 00", s, y_rsc_dat);
      end
    end
    sel = 3'd0;
    apply_reset();
  endtask

  task automatic test_taps();
    set_coef(8'h00, 8'h01, 8'h02, 8'h03, 8'h04);
    n_checks++;
    if (fsm_output !== 8'h01) begin
      n_fail++; $display("FAIL taps_wait: got %h, required 01", fsm_output);
    end
    capture(8'hAA);
    n_checks++;
    if (fsm_output !== 8'h04 || x_triosy_lz !== 1'b1) begin
      n_fail++; $display("FAIL taps_acc1: got fsm=%h xp=%b, required 04/1", fsm_output, x_triosy_lz);
    end
    for (int i = 2; i <= 5; i++) begin
      tick();
      n_checks++;
      if (fsm_output !== 8'h04 || x_triosy_lz !== 1'b0) begin
        n_fail++; $display("FAIL taps_acc%0d: got fsm=%h xp=%b, required 04/0", i, fsm_output, x_triosy_lz);
      end
    end
    tick();
    n_checks++;
    if (fsm_output !== 8'h08) begin
      n_fail++; $display("FAIL taps_write: got %h, required 08", fsm_output);
    end
    tick();
    n_checks++;
    if (fsm_output !== 8'h01 || y_triosy_lz !== 1'b1 || y_rsc_dat !== 8'h00) begin
      n_fail++; $display("FAIL taps_done: got fsm=%h yp=%b y=%h, required 01/1/00", fsm_output, y_triosy_lz, y_rsc_dat);
    end
    tick();
    sel = 3'd1; #1;
    n_checks++;
    if (y_rsc_dat !== 8'hAA) begin
      n_fail++; $display("FAIL taps_sel1: got %h, required AA", y_rsc_dat);
    end
    sel = 3'd5; #1;
    n_checks++;
    if (y_rsc_dat !== 8'h00) begin
      n_fail++; $display("FAIL taps_sel5: got %h, required 00", y_rsc_dat);
    end
    sel = 3'd0;
  endtask

  task automatic test_c0_latency();
    set_coef(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    capture(8'hAA);
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_checks++;
      if (y_triosy_lz !== (e == 6)) begin
        n_fail++; $display("FAIL c0_pulse_e%0d: got %b, required %b", e, y_triosy_lz, (e == 6));
      end
    end
    n_checks++;
    if (y_rsc_dat !== 8'h55) begin
      n_fail++; $display("FAIL c0_y: got %h, required 55", y_rsc_dat);
    end
    tick();
  endtask

  task automatic test_c1();
    apply_reset();
    set_coef(8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
    capture(8'h10);
    drain();
    n_checks++;
    if (y_rsc_dat !== 8'h00) begin
      n_fail++; $display("FAIL c1_first: got %h, required 00", y_rsc_dat);
    end
    capture(8'h20);
    drain();
    n_checks++;
    if (y_rsc_dat !== 8'h0F) begin
      n_fail++; $display("FAIL c1_second: got %h, required 0F", y_rsc_dat);
    end
    sel = 3'd2; #1;
    n_checks++;
    if (y_rsc_dat !== 8'h10) begin
      n_fail++; $display("FAIL c1_sel2: got %h, required 10", y_rsc_dat);
    end
    sel = 3'd0;
  endtask

  task automatic test_saturate();
    set_coef(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      capture(8'hFF);
      drain();
    end
    n_checks++;
    if (y_rsc_dat !== 8'hFF) begin
      n_fail++; $display("FAIL sat_y: got %h, required FF", y_rsc_dat);
    end
  endtask

  task automatic test_reset_midloop();
    set_coef(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    capture(8'h33);
    tick();
    tick();
    n_checks++;
    if (fsm_output !== 8'h04) begin
      n_fail++; $display("FAIL mid_acc3: got %h, required 04", fsm_output);
    end
    // Reset and strobe together: reset must win.
    rst = 1'b1; strobe = 1'b1; x = 8'h77;
    tick();
    rst = 1'b0; strobe = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) md[i] = 8'h00;
    n_checks++;
    if (fsm_output !== 8'h01 || y_rsc_dat !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset: got fsm=%h y=%h, required 01/00", fsm_output, y_rsc_dat);
    end
    for (int s = 1; s <= 5; s++) begin
      sel = 3'(s);
      #1;
      n_checks++;
      if (y_rsc_dat !== 8'h00) begin
        n_fail++; $display("FAIL mid_sel%0d: got %h, required 00", s, y_rsc_dat);
      end
    end
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (y_triosy_lz !== 1'b0 || fsm_output !== 8'h01) begin
        n_fail++; $display("FAIL mid_idle%0d: got yp=%b fsm=%h, required 0/01", i, y_triosy_lz, fsm_output);
      end
    end
    // Strobe held through ACC and WRITE must not cause a second capture.
    capture(8'h11);
    x = 8'h99; strobe = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (fsm_output !== 8'h08) begin
      n_fail++; $display("FAIL mid_write: got %h, required 08", fsm_output);
    end
    tick();
    strobe = 1'b0;
    n_checks++;
    if (fsm_output !== 8'h01 || y_triosy_lz !== 1'b1) begin
      n_fail++; $display("FAIL mid_done: got fsm=%h yp=%b, required 01/1", fsm_output, y_triosy_lz);
    end
    tick();
    n_checks++;
    if (fsm_output !== 8'h01) begin
      n_fail++; $display("FAIL mid_nocap: got %h, required 01", fsm_output);
    end
    sel = 3'd1; #1;
    n_checks++;
    if (y_rsc_dat !== 8'h11) begin
      n_fail++; $display("FAIL mid_d0: got %h, required 11", y_rsc_dat);
    end
    sel = 3'd2; #1;
    n_checks++;
    if (y_rsc_dat !== 8'h00) begin
      n_fail++; $display("FAIL mid_d1: got %h, required 00", y_rsc_dat);
    end
    sel = 3'd0;
  endtask

  task automatic test_back_to_back();
    set_coef(8'h10, 8'h20, 8'h30, 8'h40, 8'h50);
    strobe = 1'b1;
    for (int i = 0; i < 15; i++) begin
      x = 8'(8'h40 + i);
      if (i % 7 == 0) model_capture(x);
      tick();
      n_checks++;
      if (x_triosy_lz !== (i % 7 == 0)) begin
        n_fail++; $display("FAIL b2b_xpulse%0d: got %b, required %b", i, x_triosy_lz, (i % 7 == 0));
      end
    end
    strobe = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_taps();
    test_c0_latency();
    test_c1();
    test_saturate();
    test_reset_midloop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
